// File: rtl/arrow_scheduler.sv
// rtl/arrow_scheduler.sv - rhythm arrow spawn sequencer and hit judge; ARROW_SCHED_LOOP_EN replays the pattern forever
module arrow_scheduler #(
    parameter int CORDW       = 10,
    parameter int LANES       = 4,
    parameter int BEAT_FRAMES = 30,
    parameter int PATTERN_LEN = 16,
    parameter int HIT_Y_LO    = 3,
    parameter int HIT_Y_HI    = 60
) (
    input  logic                           clk_i,
    input  logic                           reset_ni,
    input  logic                           frame_i,
    input  logic                           start_i,
    input  logic                           pause_i,
    input  logic                           cfg_we_i,
    input  logic [$clog2(PATTERN_LEN)-1:0] cfg_addr_i,
    input  logic [LANES-1:0]               cfg_data_i,
    input  logic [LANES-1:0]               lane_busy_i,
    input  logic [LANES*CORDW-1:0]         lane_y_i,
    input  logic [LANES-1:0]               spawn_ready_i,
    output logic [LANES-1:0]               spawn_o,
    input  logic [LANES-1:0]               btn_i,
    output logic [LANES-1:0]               hit_o,
    output logic [LANES-1:0]               miss_o,
    output logic [15:0]                    score_o,
    output logic [7:0]                     combo_o,
    output logic [$clog2(PATTERN_LEN)-1:0] step_o,
    output logic [1:0]                     state_o,
    output logic                           done_o
);
    localparam int SW = $clog2(PATTERN_LEN);
    localparam int FW = $clog2(BEAT_FRAMES);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, ISSUE = 2'd2, DONE = 2'd3} state_e;

    state_e           state_q;
    logic [FW-1:0]    fcnt_q;
    logic [SW-1:0]    step_q;
    logic [LANES-1:0] pend_q;
    logic [LANES-1:0] btn_q;
    logic [LANES-1:0] hit_q, miss_q;
    logic [15:0]      score_q;
    logic [7:0]       combo_q;
    logic [LANES-1:0] pat_q [PATTERN_LEN];

    logic [LANES-1:0] btn_rise, in_win, hit_d, miss_d;
    logic [7:0]       n_hits;
    logic [16:0]      score_sum;
    logic [8:0]       combo_sum;
    logic [15:0]      score_d;
    logic [7:0]       combo_d;
    logic             beat_wrap;
    logic             last_step;

    // Pattern RAM: plain synchronous write port, never reset
    always_ff @(posedge clk_i) begin
        if (cfg_we_i) pat_q[cfg_addr_i] <= cfg_data_i;
    end

    assign beat_wrap = (fcnt_q == FW'(BEAT_FRAMES - 1));
    assign last_step = (step_q == SW'(PATTERN_LEN - 1));

    // Judge rising button edges against the lane's arrow position and fold hits into score/combo
    always_comb begin
        btn_rise = btn_i & ~btn_q;
        in_win   = '0;
        n_hits   = '0;
        for (int i = 0; i < LANES; i++) begin
            in_win[i] = (lane_y_i[i*CORDW +: CORDW] >= CORDW'(HIT_Y_LO)) &&
                        (lane_y_i[i*CORDW +: CORDW] <= CORDW'(HIT_Y_HI));
        end
        if (state_q != IDLE) begin
            hit_d  = btn_rise & lane_busy_i & in_win;
            miss_d = btn_rise & ~(lane_busy_i & in_win);
        end else begin
            hit_d  = '0;
            miss_d = '0;
        end
        for (int i = 0; i < LANES; i++) n_hits = n_hits + 8'(hit_d[i]);
        score_sum = {1'b0, score_q} + 17'(n_hits);
        combo_sum = {1'b0, combo_q} + 9'(n_hits);
        score_d   = score_sum[16] ? 16'hFFFF : score_sum[15:0];
        if (|miss_d)           combo_d = '0;
        else if (combo_sum[8]) combo_d = 8'hFF;
        else                   combo_d = combo_sum[7:0];
    end

    // Playback FSM with tempo counter, spawn bookkeeping and registered judge results
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= IDLE;
            fcnt_q  <= '0;
            step_q  <= '0;
            pend_q  <= '0;
            btn_q   <= '0;
            hit_q   <= '0;
            miss_q  <= '0;
            score_q <= '0;
            combo_q <= '0;
        end else begin
            btn_q   <= btn_i;
            hit_q   <= hit_d;
            miss_q  <= miss_d;
            score_q <= score_d;
            combo_q <= combo_d;
            case (state_q)
                IDLE, DONE: begin
                    if (start_i) begin
                        state_q <= RUN;
                        fcnt_q  <= '0;
                        step_q  <= '0;
                        score_q <= '0;
                        combo_q <= '0;
                    end
                end
                RUN: begin
                    if (!pause_i && frame_i) begin
                        if (beat_wrap) begin
                            fcnt_q  <= '0;
                            pend_q  <= pat_q[step_q] & ~lane_busy_i;
                            state_q <= ISSUE;
                        end else begin
                            fcnt_q <= fcnt_q + FW'(1);
                        end
                    end
                end
                ISSUE: begin
                    if (!pause_i) begin
                        // Tempo keeps running; a beat landing here is simply dropped
                        if (frame_i) fcnt_q <= beat_wrap ? '0 : fcnt_q + FW'(1);
                        if (pend_q == '0) begin
                            if (last_step) begin
`ifdef ARROW_SCHED_LOOP_EN
                                step_q  <= '0;
                                state_q <= RUN;
`else
                                state_q <= DONE;
`endif
                            end else begin
                                step_q  <= step_q + SW'(1);
                                state_q <= RUN;
                            end
                        end else begin
                            pend_q <= pend_q & ~spawn_ready_i;
                        end
                    end
                end
            endcase
        end
    end

    assign spawn_o = (state_q == ISSUE && !pause_i) ? pend_q : '0;
    assign hit_o   = hit_q;
    assign miss_o  = miss_q;
    assign score_o = score_q;
    assign combo_o = combo_q;
    assign step_o  = step_q;
    assign state_o = state_q;
    assign done_o  = (state_q == DONE);

endmodule

// File: doc/arrow_scheduler.md
Name: arrow_scheduler

Overview:
Sequences arrow spawns for the four-lane rhythm playfield. A programmable step pattern is played out at a tempo derived from frame_i ticks, with one spawn request per lane issued through valid/ready handshakes to the lane movers. Button presses are judged against in-flight arrow positions to produce hit/miss pulses, score and combo. The block sits between the frame timing generator and the per-lane arrow movers/renderers.

Parameters:
CORDW, 10, coordinate width of lane_y_i entries
LANES, 4, lane count; bit order {left, up, down, right} = [3:0]
BEAT_FRAMES, 30, frame_i ticks per pattern step (>=2)
PATTERN_LEN, 16, pattern RAM depth (power of 2, >=2)
HIT_Y_LO, 3, lowest y counted as a hit (inclusive)
HIT_Y_HI, 60, highest y counted as a hit (inclusive)

Ports:
clk_i  in  1  system clock
reset_ni  in  1  asynchronous active-low reset
frame_i  in  1  one-cycle pulse per video frame
start_i  in  1  start/restart playback
pause_i  in  1  hold tempo and spawning while high
cfg_we_i  in  1  pattern RAM write enable
cfg_addr_i  in  $clog2(PATTERN_LEN)  pattern RAM address
cfg_data_i  in  LANES  lane mask for step
lane_busy_i  in  LANES  lane has an arrow in flight
lane_y_i  in  LANES*CORDW  per-lane arrow y, lane i at [i*CORDW +: CORDW]
spawn_ready_i  in  LANES  mover accepts spawn
spawn_o  out  LANES  spawn request (valid)
btn_i  in  LANES  synchronised, debounced lane buttons
hit_o  out  LANES  one-cycle hit pulse per lane
miss_o  out  LANES  one-cycle miss pulse per lane
score_o  out  16  hit count, saturating
combo_o  out  8  consecutive hits, saturating
step_o  out  $clog2(PATTERN_LEN)  current step index
state_o  out  2  IDLE=0, RUN=1, ISSUE=2, DONE=3
done_o  out  1  high in DONE

Behaviour:
- Reset (async, reset_ni=0): state IDLE; spawn_o, hit_o, miss_o, score_o, combo_o, step_o, frame counter, pend mask and btn history = 0; done_o=0. Pattern RAM is not reset. Reset mid-operation aborts playback immediately.
- Pattern RAM: synchronous write on cfg_we_i in any state. Read is combinational at step_o.
- IDLE: start_i -> RUN; clear frame counter, step, score, combo.
- RUN: each unpaused frame_i increments the frame counter (width $clog2(BEAT_FRAMES)). A frame_i arriving with the counter at BEAT_FRAMES-1 wraps it to 0, loads pend = pattern[step] & ~lane_busy_i (busy lanes are skipped for this step), and enters ISSUE.
- ISSUE: spawn_o = pend when not paused, else 0. On spawn_o[i] & spawn_ready_i[i], clear pend[i] next cycle. spawn_o[i] stays high until accepted. Once pend==0 (including an empty step, which takes 1 cycle in ISSUE): if step==PATTERN_LEN-1, go to DONE; otherwise step+1 and return to RUN. The frame counter keeps counting in ISSUE to hold tempo. A wrap in ISSUE is lost; tempo is not re-queued.
- pause_i high in RUN/ISSUE: frame_i ignored, spawn_o=0, state held. Judging still runs.
- start_i in RUN/ISSUE: ignored. In DONE: restart as from IDLE.
- DONE: done_o=1, spawn_o=0.
- Judge (RUN/ISSUE/DONE, not IDLE): rising edge of btn_i[i] (against the registered previous value). It is a hit if lane_busy_i[i] and HIT_Y_LO<=y<=HIT_Y_HI, otherwise a miss. hit_o/miss_o are registered and pulse the cycle after the edge.
- Score/combo per cycle: score += popcount(hits), saturating at 0xFFFF. If any miss that cycle, combo=0. Otherwise combo += popcount(hits), saturating at 0xFF. Simultaneous lanes are evaluated independently.

Optional Feature:
ARROW_SCHED_LOOP_EN: when defined, completion of step PATTERN_LEN-1 wraps step to 0 and returns to RUN. DONE is unreachable except that the encoding is retained. When undefined, the block enters DONE as above.

Test Plan:
- BEAT_FRAMES=4, PATTERN_LEN=4, pattern {4'b1000,0,4'b0011,4'b1111}, ready tied 1, busy 0, start -> spawn_o=1000 on the 4th frame_i, nothing at the 8th, 0011 at the 12th, 1111 at the 16th, then DONE and done_o=1.
- spawn_ready_i[0] held low 10 cycles on step mask 0001 -> spawn_o=0001 held all 10 cycles, step_o frozen, advance 1 cycle after ready.
- lane_busy_i=0010 at step load with mask 0011 -> only spawn_o=0001 asserted.
- btn_i[2] rising with busy[2]=1, y=40 -> hit_o=0100 next cycle, score 0->1, combo 0->1. Then btn_i[1] rising with y=200 -> miss_o=0010, combo=0, score stays 1.
- pause_i high over 6 frame_i pulses mid-RUN -> frame counter and step unchanged, spawn_o=0. Release -> tempo resumes from the held count.
- reset_ni low mid-ISSUE with spawn_o=1111 -> spawn_o=0 and state_o=0 immediately, before any clock edge. Pattern RAM content is preserved on replay.
